// File: rtl/auto_solver.sv
// Demo/hint engine for the 2x2 sliding puzzle: checks the displayed board, picks the
// shorter blank-rotation direction to the goal and feeds one-hot moves back to the core.
module auto_solver #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk_d,
    input  logic        rst,
    input  logic [1:0]  game_status,
    input  logic        start,
    input  logic [11:0] out_game,
    output logic [3:0]  act,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic        unsolvable,
    output logic        err_timeout,
    output logic [3:0]  moves
);
    localparam logic [11:0] GOAL  = 12'b000_001_010_100;
    localparam logic [2:0]  BLANK = 3'b100;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PROBE, S_ISSUE, S_WAIT, S_GAP} state_t;

    // Ring index: 0=LU, 1=RU, 2=RD, 3=LD (clockwise order)
    function automatic logic [2:0] get_tile(input logic [11:0] b, input logic [1:0] r);
        case (r)
            2'd0:    return b[11:9];
            2'd1:    return b[8:6];
            2'd2:    return b[2:0];
            default: return b[5:3];
        endcase
    endfunction

    function automatic logic [11:0] set_tile(input logic [11:0] b, input logic [1:0] r,
                                             input logic [2:0] t);
        logic [11:0] o;
        o = b;
        case (r)
            2'd0:    o[11:9] = t;
            2'd1:    o[8:6]  = t;
            2'd2:    o[2:0]  = t;
            default: o[5:3]  = t;
        endcase
        return o;
    endfunction

    function automatic logic [1:0] blank_pos(input logic [11:0] b);
        logic [1:0] p;
        p = 2'd0;
        for (int r = 0; r < 4; r++)
            if (get_tile(b, 2'(r)) == BLANK) p = 2'(r);
        return p;
    endfunction

    function automatic logic [11:0] cw_step(input logic [11:0] b);
        logic [1:0] p;
        logic [1:0] q;
        p = blank_pos(b);
        q = p + 2'd1;
        return set_tile(set_tile(b, p, get_tile(b, q)), q, BLANK);
    endfunction

    function automatic logic board_legal(input logic [11:0] b);
        logic [2:0] c0, c1, c2, cb;
        {c0, c1, c2, cb} = '0;
        for (int r = 0; r < 4; r++)
            case (get_tile(b, 2'(r)))
                3'd0:    c0 = c0 + 3'd1;
                3'd1:    c1 = c1 + 3'd1;
                3'd2:    c2 = c2 + 3'd1;
                BLANK:   cb = cb + 3'd1;
                default: ;
            endcase
        return (c0 == 3'd1) && (c1 == 3'd1) && (c2 == 3'd1) && (cb == 3'd1);
    endfunction

    // Only rotations of (0,1,2) in clockwise order are reachable by blank moves
    function automatic logic order_ok(input logic [11:0] b);
        logic [8:0] seq;
        seq = '0;
        for (int r = 0; r < 4; r++)
            if (get_tile(b, 2'(r)) != BLANK) seq = {seq[5:0], get_tile(b, 2'(r))};
        return (seq == 9'b000_001_010) || (seq == 9'b001_010_000) || (seq == 9'b010_000_001);
    endfunction

    function automatic logic [3:0] act_code(input logic cw, input logic [1:0] p);
        if (cw)
            case (p)
                2'd0:    return 4'b0010;
                2'd1:    return 4'b0100;
                2'd2:    return 4'b1000;
                default: return 4'b0001;
            endcase
        else
            case (p)
                2'd0:    return 4'b0100;
                2'd1:    return 4'b1000;
                2'd2:    return 4'b0001;
                default: return 4'b0010;
            endcase
    endfunction

    state_t         state_q, state_d;
    logic [11:0]    shadow_q, shadow_d, snap_q, snap_d, nxt;
    logic [3:0]     dist_q, dist_d, rem_q, rem_d, moves_q, moves_d;
    logic           dir_cw_q, dir_cw_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           done_q, done_d, fail_q, fail_d, unsol_q, unsol_d, tmo_q, tmo_d;
    logic [3:0]     act_d;
    logic           gaming;

    assign gaming = (game_status == 2'b01);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        dist_d   = dist_q;
        rem_d    = rem_q;
        moves_d  = moves_q;
        dir_cw_d = dir_cw_q;
        tmr_d    = tmr_q;
        gap_d    = gap_q;
        done_d   = done_q;
        fail_d   = fail_q;
        unsol_d  = unsol_q;
        tmo_d    = tmo_q;
        act_d    = 4'b0000;
        nxt      = cw_step(shadow_q);
        if (state_q != S_IDLE && !gaming) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start && gaming) begin
                    state_d  = S_CHECK;
                    shadow_d = out_game;
                    {done_d, fail_d, unsol_d, tmo_d} = '0;
                    moves_d  = '0;
                end
                S_CHECK: begin
                    dist_d = '0;
                    if (!board_legal(shadow_q) || !order_ok(shadow_q)) begin
                        fail_d  = 1'b1;
                        unsol_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (shadow_q == GOAL) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PROBE;
                    end
                end
                S_PROBE: begin
                    shadow_d = nxt;
                    dist_d   = dist_q + 4'd1;
                    if (nxt == GOAL) begin
                        dir_cw_d = (dist_d <= 4'd6);
                        rem_d    = (dist_d <= 4'd6) ? dist_d : 4'd12 - dist_d;
                        state_d  = S_ISSUE;
                    end else if (dist_q >= 4'd11) begin
                        fail_d  = 1'b1;
                        unsol_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    act_d   = act_code(dir_cw_q, blank_pos(out_game));
                    snap_d  = out_game;
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (out_game != snap_q) begin
                        moves_d = (moves_q == 4'hF) ? moves_q : moves_q + 4'd1;
                        rem_d   = rem_q - 4'd1;
                        gap_d   = '0;
                        if (rem_q == 4'd1) begin
                            done_d  = (out_game == GOAL);
                            fail_d  = (out_game != GOAL);
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else if (tmr_q == TW'(TIMEOUT)) begin
                        fail_d  = 1'b1;
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_ISSUE;
                    else gap_d = gap_q + 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            snap_q   <= '0;
            dist_q   <= '0;
            rem_q    <= '0;
            moves_q  <= '0;
            dir_cw_q <= 1'b0;
            tmr_q    <= '0;
            gap_q    <= '0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            unsol_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            dist_q   <= dist_d;
            rem_q    <= rem_d;
            moves_q  <= moves_d;
            dir_cw_q <= dir_cw_d;
            tmr_q    <= tmr_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            unsol_q  <= unsol_d;
            tmo_q    <= tmo_d;
        end
    end

    assign act         = act_d;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign fail        = fail_q;
    assign unsolvable  = unsol_q;
    assign err_timeout = tmo_q;
    assign moves       = moves_q;
endmodule

// File: tb/tb_auto_solver.sv
// Directed bench for auto_solver with a grid-based game-core model that applies
// each act pulse to the board two cycles later.
module tb_auto_solver;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 15;
    localparam logic [11:0] GOAL = 12'b000_001_010_100;

    logic        clk_d = 1'b0;
    logic        rst;
    logic [1:0]  game_status;
    logic        start;
    logic [11:0] out_game;
    logic [3:0]  act;
    logic        busy, done, fail, unsolvable, err_timeout;
    logic [3:0]  moves;

    logic [11:0] tb_board, model_board;
    logic        core_en;
    int          cnt;
    logic [3:0]  pend;
    int          cyc = 0;
    int          pulse_cnt = 0;
    logic [3:0]  pulse_log [64];
    int          pulse_cyc [64];
    int          checks = 0;
    int          failures = 0;

    auto_solver #(.GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk_d(clk_d), .rst(rst), .game_status(game_status), .start(start),
        .out_game(out_game), .act(act), .busy(busy), .done(done), .fail(fail),
        .unsolvable(unsolvable), .err_timeout(err_timeout), .moves(moves)
    );

    always #5 clk_d = ~clk_d;
    always @(posedge clk_d) cyc <= cyc + 1;

    assign out_game = core_en ? model_board : tb_board;

    // Cell k = row*2+col lives at bits [11-3k -: 3]; moves act on the blank in the grid
    function automatic logic [11:0] apply_move(input logic [11:0] b, input logic [3:0] a);
        int k, r, c, nr, nc, nk;
        logic [11:0] o;
        logic [2:0] t;
        k = 0;
        for (int i = 0; i < 4; i++) if (b[11-3*i -: 3] == 3'b100) k = i;
        r = k / 2; c = k % 2; nr = r; nc = c;
        case (a)
            4'b0001: nr = r - 1;
            4'b0100: nr = r + 1;
            4'b1000: nc = c - 1;
            4'b0010: nc = c + 1;
            default: ;
        endcase
        o = b;
        if (nr >= 0 && nr <= 1 && nc >= 0 && nc <= 1) begin
            nk = nr * 2 + nc;
            t = b[11-3*nk -: 3];
            o[11-3*k -: 3]  = t;
            o[11-3*nk -: 3] = 3'b100;
        end
        return o;
    endfunction

    always @(negedge clk_d) begin
        if (act != 4'b0000) begin
            pulse_log[pulse_cnt] = act;
            pulse_cyc[pulse_cnt] = cyc;
            pulse_cnt = pulse_cnt + 1;
        end
        if (!core_en) begin
            model_board = tb_board;
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) model_board = apply_move(model_board, pend);
            end
            if (act != 4'b0000 && cnt == 0) begin
                pend = act;
                cnt = 2;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_d);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic load(input logic [11:0] b, input logic en);
        core_en = 1'b0;
        tb_board = b;
        tick(1);
        core_en = en;
    endtask

    task automatic wait_end(input int maxc, input string tag);
        int n;
        n = 0;
        while (!(done || fail) && n < maxc) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    int base;
    int n;
    logic ok;
    logic [3:0] exp5 [6];

    initial begin
        exp5 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        rst = 1'b1; start = 1'b0; game_status = 2'b01; core_en = 1'b0; tb_board = GOAL;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_act", {28'd0, act}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {28'd0, done, fail, unsolvable, err_timeout}, 32'd0);
        check("rst_moves", {28'd0, moves}, 32'd0);

        // 1: one CCW move from blank at LD
        load(12'b000_001_100_010, 1'b1);
        base = pulse_cnt;
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_end(80, "t1_end");
        check("t1_done", {30'd0, done, fail}, 32'd2);
        check("t1_moves", {28'd0, moves}, 32'd1);
        check("t1_npulse", pulse_cnt - base, 32'd1);
        check("t1_act", {28'd0, pulse_log[base]}, 32'b0010);
        check("t1_board", {20'd0, out_game}, {20'd0, GOAL});

        // 2: already solved
        load(GOAL, 1'b0);
        base = pulse_cnt;
        pulse_start();
        check("t2_clr", {31'd0, done}, 32'd0);
        tick(1);
        check("t2_done", {30'd0, done, fail}, 32'd2);
        check("t2_moves", {28'd0, moves}, 32'd0);
        check("t2_npulse", pulse_cnt - base, 32'd0);

        // 3: wrong cyclic order
        load(12'b001_000_010_100, 1'b0);
        base = pulse_cnt;
        pulse_start();
        tick(1);
        check("t3_flags", {28'd0, done, fail, unsolvable, err_timeout}, 32'b0110);
        tick(10);
        check("t3_npulse", pulse_cnt - base, 32'd0);

        // 4: core never responds
        load(12'b000_001_100_010, 1'b0);
        base = pulse_cnt;
        pulse_start();
        wait_end(80, "t4_end");
        check("t4_flags", {28'd0, done, fail, unsolvable, err_timeout}, 32'b0101);
        check("t4_npulse", pulse_cnt - base, 32'd1);
        check("t4_moves", {28'd0, moves}, 32'd0);
        n = cyc - pulse_cyc[base];
        ok = (n >= TIMEOUT) && (n <= TIMEOUT + 3);
        check("t4_latency", {31'd0, ok}, 32'd1);

        // 5: six CW moves from blank at LU
        load(12'b100_010_001_000, 1'b1);
        base = pulse_cnt;
        pulse_start();
        wait_end(300, "t5_end");
        check("t5_done", {30'd0, done, fail}, 32'd2);
        check("t5_moves", {28'd0, moves}, 32'd6);
        check("t5_npulse", pulse_cnt - base, 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("t5_act%0d", i), {28'd0, pulse_log[base+i]}, {28'd0, exp5[i]});
        ok = 1'b1;
        for (int i = 1; i < 6; i++) if (pulse_cyc[base+i] - pulse_cyc[base+i-1] < GAP_CYCLES + 2) ok = 1'b0;
        check("t5_spacing", {31'd0, ok}, 32'd1);
        check("t5_board", {20'd0, out_game}, {20'd0, GOAL});

        // 6a: leave GAMING while in GAP after the first acknowledged move
        load(12'b100_010_001_000, 1'b1);
        base = pulse_cnt;
        pulse_start();
        n = 0;
        while (moves != 4'd1 && n < 100) begin tick(1); n++; end
        check("t6a_ack", {28'd0, moves}, 32'd1);
        game_status = 2'b00;
        tick(1);
        check("t6a_busy", {31'd0, busy}, 32'd0);
        check("t6a_act", {28'd0, act}, 32'd0);
        check("t6a_flags", {30'd0, done, fail}, 32'd0);
        tick(20);
        check("t6a_npulse", pulse_cnt - base, 32'd1);
        check("t6a_moves", {28'd0, moves}, 32'd1);
        game_status = 2'b01;

        // 6b: reset while waiting for the third acknowledge
        load(12'b100_010_001_000, 1'b1);
        base = pulse_cnt;
        pulse_start();
        n = 0;
        while (pulse_cnt - base < 3 && n < 100) begin tick(1); n++; end
        check("t6b_moves_pre", {28'd0, moves}, 32'd2);
        rst = 1'b1;
        #2;
        check("t6b_busy", {31'd0, busy}, 32'd0);
        check("t6b_act", {28'd0, act}, 32'd0);
        check("t6b_moves", {28'd0, moves}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(30);
        check("t6b_npulse", pulse_cnt - base, 32'd3);
        check("t6b_idle", {29'd0, busy, done, fail}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
